// File: rtl/fifo_frame_tx_if.sv
// Byte-framer bus bundle: FIFO first-word-fall-through read port plus valid/ready byte stream.
// master is the framer side, slave is the FIFO/downstream side.
interface fifo_frame_tx_if;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned BYTE_W = 8;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  fifo_dout, fifo_empty, tx_ready,
    output fifo_rd_en, tx_data, tx_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid
  );
endinterface

// File: rtl/fifo_frame_tx.sv
// Capture-FIFO drain: pops one 64-bit word per frame and sends it as
// SYNC, 8 data bytes LSB first, then an optional XOR checksum byte.
module fifo_frame_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter bit         CSUM_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_frame_tx_if.master      bus,
  output logic                 busy,
  output logic [31:0]          words_sent
);
  localparam int unsigned WORD_W = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   acc_q, acc_d;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_valid_q;
  logic [CNT_W-1:0]    words_sent_q;
  logic                pop;
  logic                hs;

  // Pop is only possible from IDLE; everything else is a registered decode.
  always_comb begin
    pop   = (state_q == IDLE) & enable & ~bus.fifo_empty & ~rst;
    hs    = tx_valid_q & bus.tx_ready;
    acc_d = acc_q ^ tx_data_q;
    idx_d = idx_q + IDX_W'(1);
  end

  assign bus.fifo_rd_en = pop;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign busy           = (state_q != IDLE);
  assign words_sent     = words_sent_q;

  // Frame sequencer; tx_data_q is preloaded with the next byte on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      words_sent_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            word_q     <= bus.fifo_dout;
            idx_q      <= '0;
            acc_q      <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= SYNC;
          end
        end
        SYNC: begin
          if (hs) begin
            tx_data_q <= word_q[BYTE_W-1:0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (hs) begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            if (idx_q == IDX_W'(7)) begin
              if (CSUM_EN) begin
                tx_data_q <= acc_d;
                state_q   <= CSUM;
              end else begin
                tx_data_q    <= '0;
                tx_valid_q   <= 1'b0;
                words_sent_q <= words_sent_q + CNT_W'(1);
                state_q      <= IDLE;
              end
            end else begin
              tx_data_q <= word_q[{idx_d, 3'b000} +: BYTE_W];
            end
          end
        end
        CSUM: begin
          if (hs) begin
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            words_sent_q <= words_sent_q + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_frame_tx.sv
// Directed bench for fifo_frame_tx: checksum and no-checksum instances, small FIFO model,
// byte capture monitor and stall-stability monitor.
module tb_fifo_frame_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        enable2 = 1'b1;
  logic        busy, busy2;
  logic [31:0] ws, ws2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_frame_tx_if bus1();
  fifo_frame_tx_if bus2();

  fifo_frame_tx #(.SYNC_BYTE(8'hA5), .CSUM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus1), .busy(busy), .words_sent(ws)
  );

  fifo_frame_tx #(.SYNC_BYTE(8'hA5), .CSUM_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .bus(bus2), .busy(busy2), .words_sent(ws2)
  );

  // FIFO model for dut (first-word-fall-through)
  logic [63:0] mem [16];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign bus1.fifo_dout  = mem[rd_ptr[3:0]];
  assign bus1.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) if (bus1.fifo_rd_en && !bus1.fifo_empty) rd_ptr <= rd_ptr + 1;

  // Accepted-byte capture, pop counting and stall stability
  logic [7:0] cap [256];
  int ncap = 0;
  int npop = 0;
  int nstall = 0;
  int stall_err = 0;
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = 8'h00;
  always @(posedge clk) begin
    if (bus1.tx_valid && bus1.tx_ready) begin
      cap[ncap[7:0]] <= bus1.tx_data;
      ncap <= ncap + 1;
    end
    if (bus1.fifo_rd_en && !bus1.fifo_empty) npop <= npop + 1;
    if (pv && !pr && !prst && !rst) begin
      nstall <= nstall + 1;
      if (!bus1.tx_valid || bus1.tx_data !== pd) stall_err <= stall_err + 1;
    end
    pv   <= bus1.tx_valid;
    pr   <= bus1.tx_ready;
    pd   <= bus1.tx_data;
    prst <= rst;
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    bus1.tx_ready = 1'b1;
    bus2.tx_ready = 1'b1;
    bus2.fifo_dout = 64'h1122334455667788;
    bus2.fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    push(64'h0807060504030201);
    enable = 1'b1;
    #1;
    checks++; if (bus1.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus1.tx_valid); end
    checks++; if (bus1.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus1.tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ws !== 32'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", ws); end
    checks++; if (bus1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus1.fifo_rd_en); end
    checks++; if (bus2.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", bus2.tx_valid); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    int base_pop;
    @(negedge clk);
    base_pop = npop;
    rst = 1'b0;
    #1;
    checks++; if (bus1.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd_en: got %b want 1", bus1.fifo_rd_en); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== exp[i]) begin
        errors++; $display("FAIL basic_byte%0d: got v=%b d=%h want v=1 d=%h", i, bus1.tx_valid, bus1.tx_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++; if (bus1.tx_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid: got %b want 0", bus1.tx_valid); end
    checks++; if (ws !== 32'd1) begin errors++; $display("FAIL basic_words: got %0d want 1", ws); end
    checks++; if ((npop - base_pop) !== 1) begin errors++; $display("FAIL basic_pops: got %0d want 1", npop - base_pop); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] e;
    @(negedge clk);
    base = ncap;
    push(64'hFFFFFFFFFFFFFFFF);
    push(64'h0000000000000000);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      checks++; if (bus1.tx_valid !== (i != 10)) begin
        errors++; $display("FAIL b2b_valid_cycle%0d: got %b want %b", i, bus1.tx_valid, (i != 10));
      end
    end
    @(negedge clk);
    checks++; if (ws !== 32'd3) begin errors++; $display("FAIL b2b_words: got %0d want 3", ws); end
    checks++; if ((ncap - base) !== 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", ncap - base); end
    for (int i = 0; i < 20; i++) begin
      e = (i % 10 == 0) ? 8'hA5 : ((i < 9) ? 8'hFF : 8'h00);
      checks++; if (cap[base + i] !== e) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, cap[base + i], e);
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    logic [15:0] pat = 16'b0110_1001_1100_1010;
    int base, se0, ns0, i;
    @(negedge clk);
    base = ncap; se0 = stall_err; ns0 = nstall;
    push(64'h0807060504030201);
    bus1.tx_ready = pat[0];
    i = 1;
    while (ws !== 32'd4 && i < 200) begin
      @(negedge clk);
      bus1.tx_ready = pat[i % 16];
      i++;
    end
    bus1.tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (ws !== 32'd4) begin errors++; $display("FAIL stall_words: got %0d want 4", ws); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (cap[base + k] !== exp[k]) begin
        errors++; $display("FAIL stall_byte%0d: got %h want %h", k, cap[base + k], exp[k]);
      end
    end
    checks++; if (stall_err !== se0) begin errors++; $display("FAIL stall_hold: got %0d violations want 0", stall_err - se0); end
    checks++; if ((nstall > ns0) !== 1'b1) begin errors++; $display("FAIL stall_seen: got %0d stall cycles want >0", nstall - ns0); end
  endtask

  task automatic test_enable;
    logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h67};
    int base, bad;
    @(negedge clk);
    enable = 1'b0;
    base = ncap;
    push(64'h5A00000000003C01);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus1.fifo_rd_en !== 1'b0 || bus1.tx_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_off_idle: got %0d active cycles want 0", bad); end
    enable = 1'b1;
    #1;
    checks++; if (bus1.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL en_on_rd_en: got %b want 1", bus1.fifo_rd_en); end
    @(negedge clk);
    checks++; if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== 8'hA5) begin
      errors++; $display("FAIL en_start: got v=%b d=%h want v=1 d=a5", bus1.tx_valid, bus1.tx_data);
    end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_done: got busy=%b want 0", busy); end
    checks++; if (ws !== 32'd5) begin errors++; $display("FAIL en_words: got %0d want 5", ws); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (cap[base + k] !== exp[k]) begin
        errors++; $display("FAIL en_byte%0d: got %h want %h", k, cap[base + k], exp[k]);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    @(negedge clk);
    push(64'h7766554433221100);
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1 || bus1.tx_data !== 8'h44) begin
      errors++; $display("FAIL rmid_at_idx4: got busy=%b d=%h want busy=1 d=44", busy, bus1.tx_data);
    end
    push(64'h8040201008040201);
    rst = 1'b1;
    #1;
    checks++; if (bus1.tx_valid !== 1'b0 || bus1.tx_data !== 8'h00) begin
      errors++; $display("FAIL rmid_outputs: got v=%b d=%h want v=0 d=00", bus1.tx_valid, bus1.tx_data);
    end
    checks++; if (busy !== 1'b0 || ws !== 32'd0) begin
      errors++; $display("FAIL rmid_state: got busy=%b words=%0d want 0/0", busy, ws);
    end
    checks++; if (bus1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_rd_en: got %b want 0", bus1.fifo_rd_en); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== exp[i]) begin
        errors++; $display("FAIL rmid_byte%0d: got v=%b d=%h want v=1 d=%h", i, bus1.tx_valid, bus1.tx_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++; if (bus1.tx_valid !== 1'b0 || ws !== 32'd1) begin
      errors++; $display("FAIL rmid_end: got v=%b words=%0d want v=0 words=1", bus1.tx_valid, ws);
    end
  endtask

  task automatic test_nocsum;
    logic [7:0] exp [9] = '{8'hA5, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    bus2.fifo_empty = 1'b0;
    #1;
    checks++; if (bus2.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL nocsum_rd_en: got %b want 1", bus2.fifo_rd_en); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus2.fifo_empty = 1'b1;
      checks++; if (bus2.tx_valid !== 1'b1 || bus2.tx_data !== exp[i]) begin
        errors++; $display("FAIL nocsum_byte%0d: got v=%b d=%h want v=1 d=%h", i, bus2.tx_valid, bus2.tx_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++; if (bus2.tx_valid !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL nocsum_idle: got v=%b busy=%b want 0/0", bus2.tx_valid, busy2);
    end
    checks++; if (ws2 !== 32'd1) begin errors++; $display("FAIL nocsum_words: got %0d want 1", ws2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_enable();
    test_reset_mid();
    test_nocsum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
